// File: rtl/traffic_controller_param.sv
// Parameterised phase-based traffic light controller with green extension, demand-driven
// phase skipping, and a flashing-yellow override followed by an all-red clearance.
module traffic_controller_param #(
  parameter int unsigned                        NUM_LIGHTS = 6,
  parameter int unsigned                        NUM_PHASES = 3,
  parameter logic [NUM_PHASES*NUM_LIGHTS-1:0]   PHASE_MASK = 18'h388CD,
  parameter int unsigned                        TICK_DIV   = 50_000_000,
  parameter int unsigned                        T_RY       = 1,
  parameter int unsigned                        T_G        = 2,
  parameter int unsigned                        T_Y        = 1,
  parameter int unsigned                        T_R        = 1,
  parameter int unsigned                        T_EXT      = 1,
  parameter int unsigned                        MAX_EXT    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_PHASES-1:0]     demand,
  input  logic                      ext_req,
  input  logic                      flash,
  output logic [3*NUM_LIGHTS-1:0]   lights,
  output logic [2:0]                phase,
  output logic [1:0]                sub_state,
  output logic                      flashing
);

  if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_phases
    $error("NUM_PHASES out of range");
  end
  if (NUM_LIGHTS < 1 || TICK_DIV < 1) begin : g_bad_div
    $error("NUM_LIGHTS and TICK_DIV must be at least 1");
  end
  if (T_RY < 1 || T_RY > 65535 || T_G < 1 || T_G > 65535 || T_Y < 1 || T_Y > 65535 ||
      T_R < 1 || T_R > 65535 || T_EXT < 1 || T_EXT > 65535) begin : g_bad_dur
    $error("sub-state duration out of range");
  end

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

  typedef enum logic [1:0] {ModeRun, ModeFlash, ModeClear} mode_e;
  typedef enum logic [1:0] {SubRy = 2'b00, SubG = 2'b01, SubY = 2'b10, SubR = 2'b11} sub_e;

  mode_e                 mode_q;
  sub_e                  sub_q;
  logic [2:0]            phase_q;
  logic [PW-1:0]         presc_q;
  logic [15:0]           timer_q;
  logic [EW-1:0]         ext_cnt_q;
  logic [NUM_PHASES-1:0] req_q;
  logic                  flash_on_q;

  logic                  tick;
  logic                  expire;
  logic [2:0]            next_phase;
  logic                  found;
  int                    idx;
  logic [NUM_PHASES-1:0] phase_hot;
  logic [2:0]            sub_colour;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign expire = tick && (timer_q == 16'd1);

  always_comb begin
    for (int p = 0; p < int'(NUM_PHASES); p++) begin
      phase_hot[p] = (int'(phase_q) == p);
    end
  end

  // Search starts after the current phase and wraps, so the current phase is checked last.
  always_comb begin
    next_phase = (int'(phase_q) == int'(NUM_PHASES) - 1) ? 3'd0 : phase_q + 3'd1;
    found      = 1'b0;
    idx        = 0;
    for (int i = 1; i <= int'(NUM_PHASES); i++) begin
      idx = (int'(phase_q) + i) % int'(NUM_PHASES);
      if (!found && req_q[idx]) begin
        found      = 1'b1;
        next_phase = 3'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= ModeRun;
      sub_q      <= SubRy;
      phase_q    <= 3'd0;
      presc_q    <= '0;
      timer_q    <= 16'(T_RY);
      ext_cnt_q  <= '0;
      req_q      <= '0;
      flash_on_q <= 1'b0;
    end else if (flash) begin
      req_q <= req_q | demand;
      if (mode_q != ModeFlash) begin
        mode_q     <= ModeFlash;
        presc_q    <= '0;
        flash_on_q <= 1'b1;
      end else if (tick) begin
        presc_q    <= '0;
        flash_on_q <= ~flash_on_q;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end else begin
      req_q <= req_q | demand;
      case (mode_q)
        ModeFlash: begin
          mode_q  <= ModeClear;
          presc_q <= '0;
          timer_q <= 16'(T_R);
        end
        ModeClear: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (expire) begin
            mode_q    <= ModeRun;
            phase_q   <= 3'd0;
            sub_q     <= SubRy;
            timer_q   <= 16'(T_RY);
            ext_cnt_q <= '0;
          end else if (tick) begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (expire) begin
            unique case (sub_q)
              SubRy: begin
                sub_q   <= SubG;
                timer_q <= 16'(T_G);
                req_q   <= (req_q | demand) & ~phase_hot;
              end
              SubG: begin
                if (ext_req && (ext_cnt_q < EW'(MAX_EXT))) begin
                  timer_q   <= 16'(T_EXT);
                  ext_cnt_q <= ext_cnt_q + 1'b1;
                end else begin
                  sub_q   <= SubY;
                  timer_q <= 16'(T_Y);
                end
              end
              SubY: begin
                sub_q   <= SubR;
                timer_q <= 16'(T_R);
              end
              SubR: begin
                sub_q     <= SubRy;
                timer_q   <= 16'(T_RY);
                ext_cnt_q <= '0;
                phase_q   <= next_phase;
              end
            endcase
          end else if (tick) begin
            timer_q <= timer_q - 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    unique case (sub_q)
      SubRy:   sub_colour = 3'b110;
      SubG:    sub_colour = 3'b001;
      SubY:    sub_colour = 3'b010;
      default: sub_colour = 3'b100;
    endcase
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < int'(NUM_LIGHTS); i++) begin
      case (mode_q)
        ModeFlash: lights[3*i +: 3] = flash_on_q ? 3'b010 : 3'b000;
        ModeClear: lights[3*i +: 3] = 3'b100;
        default: begin
          lights[3*i +: 3] = PHASE_MASK[int'(phase_q) * int'(NUM_LIGHTS) + i] ?
                             sub_colour : 3'b100;
        end
      endcase
    end
  end

  assign phase     = phase_q;
  assign sub_state = sub_q;
  assign flashing  = (mode_q == ModeFlash);

endmodule

// File: tb/tb_traffic_controller_param.sv
// Directed and randomized bench for traffic_controller_param, checked against a cycle-count
// reference model of the phase/sub-state/flash rules.
module tb_traffic_controller_param;

  localparam int unsigned TD      = 2;
  localparam int unsigned T_RY    = 1;
  localparam int unsigned T_G     = 3;
  localparam int unsigned T_Y     = 1;
  localparam int unsigned T_R     = 1;
  localparam int unsigned T_EXT   = 1;
  localparam int unsigned MAX_EXT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  demand;
  logic        ext_req;
  logic        flash;
  logic [17:0] lights;
  logic [2:0]  phase;
  logic [1:0]  sub_state;
  logic        flashing;

  always #5 clk = ~clk;

  traffic_controller_param #(
    .NUM_LIGHTS (6),
    .NUM_PHASES (3),
    .PHASE_MASK (18'h388CD),
    .TICK_DIV   (TD),
    .T_RY       (T_RY),
    .T_G        (T_G),
    .T_Y        (T_Y),
    .T_R        (T_R),
    .T_EXT      (T_EXT),
    .MAX_EXT    (MAX_EXT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .demand    (demand),
    .ext_req   (ext_req),
    .flash     (flash),
    .lights    (lights),
    .phase     (phase),
    .sub_state (sub_state),
    .flashing  (flashing)
  );

  // Model: mode 0=run 1=flash 2=clear; left = cycles remaining in the current interval.
  logic [5:0] m_mask [3] = '{6'b001101, 6'b100011, 6'b111000};
  int         m_mode, m_phase, m_sub, m_left, m_ext, m_fcnt;
  logic [2:0] m_req;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_lights();
    logic [17:0] v;
    logic [2:0]  c;
    v = '0;
    case (m_sub)
      0:       c = 3'b110;
      1:       c = 3'b001;
      2:       c = 3'b010;
      default: c = 3'b100;
    endcase
    for (int i = 0; i < 6; i++) begin
      if (m_mode == 1)      v[3*i +: 3] = ((m_fcnt / TD) % 2 == 0) ? 3'b010 : 3'b000;
      else if (m_mode == 2) v[3*i +: 3] = 3'b100;
      else                  v[3*i +: 3] = m_mask[m_phase][i] ? c : 3'b100;
    end
    return v;
  endfunction

  task automatic model_step();
    logic [2:0] rq;
    int         np;
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_sub = 0; m_left = T_RY * TD; m_ext = 0; m_req = '0;
      return;
    end
    rq = m_req | demand;
    if (flash) begin
      if (m_mode != 1) begin m_mode = 1; m_fcnt = 0; end
      else m_fcnt++;
    end else if (m_mode == 1) begin
      m_mode = 2; m_left = T_R * TD;
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 0; m_phase = 0; m_sub = 0; m_left = T_RY * TD; m_ext = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        case (m_sub)
          0: begin m_sub = 1; m_left = T_G * TD; rq[m_phase] = 1'b0; end
          1: begin
            if (ext_req && m_ext < MAX_EXT) begin m_ext++; m_left = T_EXT * TD; end
            else begin m_sub = 2; m_left = T_Y * TD; end
          end
          2: begin m_sub = 3; m_left = T_R * TD; end
          default: begin
            np = (m_phase + 1) % 3;
            for (int k = 3; k >= 1; k--) begin
              if (m_req[(m_phase + k) % 3]) np = (m_phase + k) % 3;
            end
            m_phase = np; m_sub = 0; m_left = T_RY * TD; m_ext = 0;
          end
        endcase
      end
    end
    m_req = rq;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("lights", 32'(lights), 32'(exp_lights()));
    chk("phase", 32'(phase), m_phase);
    chk("sub_state", 32'(sub_state), (m_mode == 0 || m_mode == 2 || m_mode == 1) ? m_sub : 0);
    chk("flashing", 32'(flashing), (m_mode == 1) ? 1 : 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // lft < 0 matches any remaining count
  task automatic wait_until(input int ph, input int sb, input int lft, input string tag);
    int  n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (n < 200) begin
      if (m_mode == 0 && m_phase == ph && m_sub == sb && (lft < 0 || m_left == lft)) begin
        hit = 1'b1;
        break;
      end
      step();
      n++;
    end
    chk(tag, 32'(hit), 1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; demand = 3'b111; ext_req = 1'b1; flash = 1'b0;
    m_mode = 0; m_phase = 0; m_sub = 0; m_left = T_RY * TD; m_ext = 0; m_req = '0; m_fcnt = 0;
    steps(2);
    chk("reset_lights", 32'(lights), 32'(18'o446646));

    // Free-running cycle through all phases
    rst_n = 1'b1; demand = '0; ext_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m_phase == 1 && m_sub == 1) chk("p1_green", 32'(lights), 32'(18'o144411));
    end

    // Green extension: two accepted, third refused
    wait_until(0, 0, -1, "wait_p0_ry");
    ext_req = 1'b1;
    wait_until(0, 1, -1, "wait_p0_g");
    cnt = 0;
    while (sub_state == 2'b01 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("ext_g_len", cnt, 10);
    ext_req = 1'b0;

    // Demand for phase 2 skips phase 1
    wait_until(0, 1, -1, "wait_p0_g2");
    demand = 3'b100;
    step();
    demand = '0;
    wait_until(0, 3, 1, "wait_p0_r");
    step();
    chk("skip_to_p2", 32'(phase), 2);

    // Demand coincident with phase 1 green entry is cleared
    wait_until(1, 0, 1, "wait_p1_ry_last");
    demand = 3'b010;
    step();
    demand = '0;
    wait_until(2, 3, 1, "wait_p2_r");
    step();
    chk("req1_cleared", 32'(phase), 0);

    // Flash override mid phase 1 green, then clearance
    wait_until(1, 1, -1, "wait_p1_g");
    steps(2);
    flash = 1'b1;
    step();
    chk("flash_entry", 32'(flashing), 1);
    steps(8);
    flash = 1'b0;
    step();
    chk("clear_red", 32'(lights), 32'(18'o444444));
    steps(2);
    chk("clear_exit", 32'(lights), 32'(18'o446646));

    // Reset during flash and during phase 2 yellow
    flash = 1'b1;
    steps(3);
    rst_n = 1'b0;
    step();
    chk("rst_in_flash", 32'(lights), 32'(18'o446646));
    rst_n = 1'b1; flash = 1'b0;
    demand = 3'b100;
    step();
    demand = '0;
    wait_until(2, 2, -1, "wait_p2_y");
    rst_n = 1'b0;
    step();
    chk("rst_in_p2y", 32'(phase), 0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) flash = ~flash;
      rst_n   = ($urandom_range(0, 399) != 0);
      demand  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      ext_req = 1'($urandom_range(0, 1));
      step();
    end
    flash = 1'b0; demand = '0; ext_req = 1'b0;
    steps(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
